pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 21 ++
 rtl/adder_slice.sv | 30 +++
 rtl/pipelined_adder.sv | 173 +++++++++++++++++
 tb/tb_pipelined_adder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract unit.
// Operation encoding, chunk sizing and the last-stage flag bookkeeping.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Operand MSBs of the top chunk and "all lower chunks zero", captured with the final chunk
  typedef struct packed {
    logic a_msb;
    logic b_msb;
    logic lo_zero;
  } tail_t;

endpackage

// File: rtl/adder_slice.sv
// One CHUNK-wide registered adder stage with carry in/out.
// Sum and carry are held while load is low.
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CHUNK-1:0] a_in,
  input  logic [CHUNK-1:0] b_in,
  input  logic             cin,
  output logic [CHUNK-1:0] sum_q,
  output logic             cout_q
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a_in} + {1'b0, b_in} + {{CHUNK{1'b0}}, cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (load) begin
      sum_q  <= total[CHUNK-1:0];
      cout_q <= total[CHUNK];
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement add/subtract with chunked carry propagation.
// Each stage resolves one carry chunk; valid/ready handshake with full backpressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_e              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  logic [WIDTH-1:0]  b_cond;
  logic              c0;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] ld;
  logic              go_chain;

  always_comb begin
    b_cond = (op == OP_SUB) ? ~b : b;
    c0     = (op == OP_SUB) ? 1'b1 : cin;
  end

  // A stage may load if it is empty or its occupant moves on this edge
  always_comb begin
    ld       = '0;
    go_chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k]    = !v[k] || go_chain;
      go_chain = ld[k];
    end
  end

  always_comb begin
    v_in    = '0;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v[k-1];
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v[LAST];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) v[k] <= v_in[k];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0]         a_in;
    logic [CHUNK-1:0]         b_in;
    logic                     c_in;
    logic [CHUNK-1:0]         sum_q;
    logic                     cout_q;
    logic                     load;
    logic [(k+1)*CHUNK-1:0]   res_done;

    // Only real beats are captured, so stalled or empty stages keep their data
    assign load = ld[k] && v_in[k];

    if (k == 0) begin : g_src
      assign a_in = a[CHUNK-1:0];
      assign b_in = b_cond[CHUNK-1:0];
      assign c_in = c0;
    end else begin : g_src
      assign a_in = g_stage[k-1].g_skew.a_sk[CHUNK-1:0];
      assign b_in = g_stage[k-1].g_skew.b_sk[CHUNK-1:0];
      assign c_in = g_stage[k-1].cout_q;
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .a_in   (a_in),
      .b_in   (b_in),
      .cin    (c_in),
      .sum_q  (sum_q),
      .cout_q (cout_q)
    );

    if (k == 0) begin : g_res
      assign res_done = sum_q;
    end else begin : g_res
      logic [k*CHUNK-1:0] r_lo;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_lo <= '0;
        end else if (load) begin
          r_lo <= g_stage[k-1].res_done;
        end
      end

      assign res_done = {sum_q, r_lo};
    end

    // Operand chunks not yet added ride along with the beat
    if (k < LAST) begin : g_skew
      localparam int SW = WIDTH - (k + 1) * CHUNK;
      logic [SW-1:0] a_sk;
      logic [SW-1:0] b_sk;
      logic [SW-1:0] a_nx;
      logic [SW-1:0] b_nx;

      if (k == 0) begin : g_nx
        assign a_nx = a[WIDTH-1:CHUNK];
        assign b_nx = b_cond[WIDTH-1:CHUNK];
      end else begin : g_nx
        assign a_nx = g_stage[k-1].g_skew.a_sk[WIDTH-k*CHUNK-1:CHUNK];
        assign b_nx = g_stage[k-1].g_skew.b_sk[WIDTH-k*CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_sk <= '0;
          b_sk <= '0;
        end else if (load) begin
          a_sk <= a_nx;
          b_sk <= b_nx;
        end
      end
    end
  end

  logic  lower_zero;
  tail_t tail_q;

  if (LAST == 0) begin : g_lz
    assign lower_zero = 1'b1;
  end else begin : g_lz
    assign lower_zero = (g_stage[LAST-1].res_done == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_q <= '0;
    end else if (g_stage[LAST].load) begin
      tail_q.a_msb   <= g_stage[LAST].a_in[CHUNK-1];
      tail_q.b_msb   <= g_stage[LAST].b_in[CHUNK-1];
      tail_q.lo_zero <= lower_zero;
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits
  assign s    = g_stage[LAST].res_done;
  assign cout = g_stage[LAST].cout_q;
  assign ovf  = tail_q.a_msb ^ tail_q.b_msb ^ s[WIDTH-1] ^ cout;
  assign zero = tail_q.lo_zero && (g_stage[LAST].sum_q == '0);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder (32b/4 stages and 64b/1 stage)
// against a plain-arithmetic reference model with an in-order expectation queue.
module tb_pipelined_adder;
  import adder_pkg::*;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a64;
  logic [63:0] b64;
  logic        cin;
  op_e         op;

  logic        rdy32, ov32, co32, of32, z32;
  logic [31:0] s32;
  logic        rdy64, ov64, co64, of64, z64;
  logic [63:0] s64;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cycle = 0;
  bit   exact_lat = 0;
  bit   last_acc32;
  exp_t q32[$];
  exp_t q64[$];
  exp_t held[2];
  bit   held_v[2];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .a(a64[31:0]), .b(b64[31:0]), .cin(cin), .op(op),
    .out_valid(ov32), .out_ready(out_ready), .s(s32), .cout(co32), .ovf(of32), .zero(z32)
  );

  pipelined_adder #(.WIDTH(64), .STAGES(1)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
    .a(a64), .b(b64), .cin(cin), .op(op),
    .out_valid(ov64), .out_ready(out_ready), .s(s64), .cout(co64), .ovf(of64), .zero(z64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference: modular add of the conditioned operands; overflow by the sign rule
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input bit sub, input int cyc);
    exp_t        e;
    logic [63:0] mask, am, bm, bb;
    logic [64:0] full;
    logic        sa, sb, ss;
    mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am     = a & mask;
    bm     = b & mask;
    bb     = sub ? (~bm & mask) : bm;
    full   = {1'b0, am} + {1'b0, bb} + {64'd0, (sub ? 1'b1 : ci)};
    e.s    = full[63:0] & mask;
    e.cout = full[w];
    sa     = am[w-1];
    sb     = bm[w-1];
    ss     = e.s[w-1];
    e.ovf  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    e.zero = (e.s == 64'd0);
    e.cyc  = cyc;
    return e;
  endfunction

  task automatic sb(input int d, input string nm, input int w, input int lat, input logic acc,
                    input logic ov, input logic [63:0] s, input logic co, input logic of, input logic z);
    exp_t e;
    int   qs;
    if (held_v[d]) begin
      check({nm, "_hold_valid"}, {63'd0, ov}, 64'd1);
      check({nm, "_hold_s"}, s, held[d].s);
      check({nm, "_hold_flags"}, {61'd0, co, of, z}, {61'd0, held[d].cout, held[d].ovf, held[d].zero});
    end
    held_v[d] = ov && !out_ready;
    held[d]   = '{s: s, cout: co, ovf: of, zero: z, cyc: 0};
    if (ov && out_ready) begin
      qs = (d == 0) ? q32.size() : q64.size();
      if (qs == 0) begin
        check({nm, "_spurious_out"}, 64'(qs), 64'd1);
      end else begin
        e = (d == 0) ? q32.pop_front() : q64.pop_front();
        check({nm, "_s"}, s, e.s);
        check({nm, "_cout"}, {63'd0, co}, {63'd0, e.cout});
        check({nm, "_ovf"}, {63'd0, of}, {63'd0, e.ovf});
        check({nm, "_zero"}, {63'd0, z}, {63'd0, e.zero});
        if (exact_lat) check({nm, "_latency"}, 64'(cycle - e.cyc), 64'(lat));
        else           check({nm, "_latency_min"}, {63'd0, (cycle - e.cyc) >= lat}, 64'd1);
      end
    end
    if (acc) begin
      e = model(w, a64, b64, cin, op == OP_SUB, cycle);
      if (d == 0) q32.push_back(e);
      else        q64.push_back(e);
    end
  endtask

  // Inputs change at the falling edge; handshakes are judged just after and commit at the next rise
  task automatic tick();
    #1;
    last_acc32 = in_valid && rdy32;
    sb(0, "w32", 32, 4, in_valid && rdy32, ov32, {32'd0, s32}, co32, of32, z32);
    sb(1, "w64", 64, 1, in_valid && rdy64, ov64, s64, co64, of64, z64);
    cycle++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic c, input op_e o);
    in_valid = 1'b1;
    a64 = a;
    b64 = b;
    cin = c;
    op  = o;
    tick();
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_w32_out_valid"}, {63'd0, ov32}, 64'd0);
    check({nm, "_w32_s"}, {32'd0, s32}, 64'd0);
    check({nm, "_w32_flags"}, {61'd0, co32, of32, z32}, 64'd0);
    check({nm, "_w32_in_ready"}, {63'd0, rdy32}, 64'd1);
    check({nm, "_w64_out_valid"}, {63'd0, ov64}, 64'd0);
    check({nm, "_w64_s"}, s64, 64'd0);
    check({nm, "_w64_in_ready"}, {63'd0, rdy64}, 64'd1);
  endtask

  task automatic drain(input string nm);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (q32.size() != 0 || q64.size() != 0); i++) tick();
    check({nm, "_w32_drained"}, 64'(q32.size()), 64'd0);
    check({nm, "_w64_drained"}, 64'(q64.size()), 64'd0);
  endtask

  initial begin
    int acc_cnt;
    int idx;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a64 = '0;
    b64 = '0;
    cin = 1'b0;
    op = OP_ADD;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_released");

    // ADD streaming, carry ripple, overflow, borrow cases with exact latency
    exact_lat = 1;
    beat(64'd0, 64'd4, 1'b0, OP_ADD);
    beat(64'd4, 64'd4, 1'b0, OP_ADD);
    beat(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, OP_ADD);
    beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, OP_ADD);
    beat(64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0, OP_ADD);
    beat(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OP_ADD);
    beat(64'h0000_0000_8000_0000, 64'd1, 1'b0, OP_SUB);
    beat(64'h8000_0000_0000_0000, 64'd1, 1'b0, OP_SUB);
    beat(64'd5, 64'd7, 1'b1, OP_SUB);
    beat(64'd9, 64'd9, 1'b0, OP_SUB);
    beat(64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 1'b0, OP_ADD);
    drain("directed");
    exact_lat = 0;

    // Reset with three beats in flight: none may emerge afterwards
    out_ready = 1'b1;
    beat(64'd11, 64'd22, 1'b0, OP_ADD);
    beat(64'd33, 64'd44, 1'b0, OP_ADD);
    beat(64'd55, 64'd66, 1'b0, OP_SUB);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    q32.delete();
    q64.delete();
    held_v[0] = 0;
    held_v[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("after_reset_no_out_w32", {63'd0, ov32}, 64'd0);
      tick();
    end

    // Backpressure: fill with out_ready low, then release
    out_ready = 1'b0;
    idx = 0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      beat(64'(idx), 64'(idx * 3), 1'b0, OP_ADD);
      if (last_acc32) begin
        idx++;
        acc_cnt++;
      end
    end
    check("stall_accepted_w32", 64'(acc_cnt), 64'd4);
    check("stall_in_ready_w32", {63'd0, rdy32}, 64'd0);
    check("stall_in_ready_w64", {63'd0, rdy64}, 64'd0);
    out_ready = 1'b1;
    a64 = 64'(idx);
    b64 = 64'(idx * 3);
    #1;
    check("passthrough_in_ready_w32", {63'd0, rdy32}, 64'd1);
    for (int i = 0; i < 30 && idx < 8; i++) begin
      beat(64'(idx), 64'(idx * 3), 1'b0, OP_ADD);
      if (last_acc32) idx++;
    end
    check("stream_all_sent", 64'(idx), 64'd8);
    drain("backpressure");

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: a64 = '1;
        1: b64 = '0;
        2: b64 = a64;
        default: ;
      endcase
      cin = $urandom_range(0, 1) != 0;
      op  = ($urandom_range(0, 1) != 0) ? OP_SUB : OP_ADD;
      tick();
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
